// File: rtl/matrix_bram_pkg.sv
// Shared layout of the matrix BRAM: per-block metadata offsets, dimension-word fields,
// writer state encoding and block base address helper. Used by matrix_writer and matrix_reader.
package matrix_bram_pkg;

  localparam int MB_BLOCK_SIZE = 1152;
  localparam int MB_ADDR_WIDTH = 14;

  localparam int META_DIM_OFS     = 0;
  localparam int META_NAME_LO_OFS = 1;
  localparam int META_NAME_HI_OFS = 2;
  localparam int DATA_OFS         = 3;

  localparam int ROWS_MSB = 31;
  localparam int ROWS_LSB = 24;
  localparam int COLS_MSB = 23;
  localparam int COLS_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_META0,
    ST_META1,
    ST_META2,
    ST_DATA,
    ST_DONE
  } mw_state_t;

  function automatic logic [MB_ADDR_WIDTH-1:0] block_base(input logic [2:0] id);
    return MB_ADDR_WIDTH'(id) * MB_ADDR_WIDTH'(MB_BLOCK_SIZE);
  endfunction

endpackage

// File: rtl/matrix_writer.sv
// Writes one matrix (3 metadata words, then a row-major element stream) into its BRAM block.
// First BRAM write one cycle after the accepted request; elements land one cycle after each valid/ready beat.
module matrix_writer
  import matrix_bram_pkg::*;
#(
  parameter int MAX_MEMORY_MATRIXES = 8,
  parameter int BLOCK_SIZE          = 1152,
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 14
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   write_req,
  input  logic [$clog2(MAX_MEMORY_MATRIXES)-1:0] matrix_id,
  input  logic [7:0]                             rows,
  input  logic [7:0]                             cols,
  input  logic [63:0]                            matrix_name,
  output logic                                   writer_ready,
  input  logic [DATA_WIDTH-1:0]                  data_in,
  input  logic                                   data_valid,
  output logic                                   data_ready,
  output logic                                   write_done,
  output logic                                   write_error,
  output logic                                   bram_we,
  output logic [ADDR_WIDTH-1:0]                  bram_addr,
  output logic [DATA_WIDTH-1:0]                  bram_din
);

  localparam int MAX_ELEMS = BLOCK_SIZE - DATA_OFS;

  mw_state_t             state;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [63:0]           name_r;
  logic [10:0]           total_r;
  logic [10:0]           count;

  logic [15:0]           req_total;
  logic                  req_ok;
  logic [ADDR_WIDTH-1:0] req_base;
  logic [DATA_WIDTH-1:0] dim_word;

  assign req_total = 16'(rows) * 16'(cols);
  assign req_ok    = (rows != 8'd0) && (cols != 8'd0) && (req_total <= 16'(MAX_ELEMS));
  assign req_base  = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);

  // The dimension word is written on the accept edge, so it is built from the live inputs.
  always_comb begin
    dim_word                    = '0;
    dim_word[ROWS_MSB:ROWS_LSB] = rows;
    dim_word[COLS_MSB:COLS_LSB] = cols;
  end

  assign writer_ready = (state == ST_IDLE);
  assign data_ready   = (state == ST_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      base_r      <= '0;
      name_r      <= '0;
      total_r     <= '0;
      count       <= '0;
      write_done  <= 1'b0;
      write_error <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
    end else begin
      write_done  <= 1'b0;
      write_error <= 1'b0;
      bram_we     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (write_req) begin
            if (req_ok) begin
              base_r    <= req_base;
              name_r    <= matrix_name;
              total_r   <= req_total[10:0];
              count     <= '0;
              bram_we   <= 1'b1;
              bram_addr <= req_base + ADDR_WIDTH'(META_DIM_OFS);
              bram_din  <= dim_word;
              state     <= ST_META0;
            end else begin
              write_error <= 1'b1;
            end
          end
        end
        ST_META0: begin
          bram_we   <= 1'b1;
          bram_addr <= base_r + ADDR_WIDTH'(META_NAME_LO_OFS);
          bram_din  <= DATA_WIDTH'(name_r[31:0]);
          state     <= ST_META1;
        end
        ST_META1: begin
          bram_we   <= 1'b1;
          bram_addr <= base_r + ADDR_WIDTH'(META_NAME_HI_OFS);
          bram_din  <= DATA_WIDTH'(name_r[63:32]);
          state     <= ST_META2;
        end
        ST_META2: begin
          state <= ST_DATA;
        end
        ST_DATA: begin
          if (data_valid) begin
            bram_we   <= 1'b1;
            bram_addr <= base_r + ADDR_WIDTH'(DATA_OFS) + ADDR_WIDTH'(count);
            bram_din  <= data_in;
            count     <= count + 11'd1;
            if (count == total_r - 11'd1) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          write_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_writer.sv
// Randomized and directed bench for matrix_writer against a block-layout reference model.
module tb_matrix_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_req;
  logic [2:0]  matrix_id;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic [63:0] matrix_name;
  logic        writer_ready;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        write_done;
  logic        write_error;
  logic        bram_we;
  logic [13:0] bram_addr;
  logic [31:0] bram_din;

  matrix_writer dut (
    .clk          (clk),
    .rst          (rst),
    .write_req    (write_req),
    .matrix_id    (matrix_id),
    .rows         (rows),
    .cols         (cols),
    .matrix_name  (matrix_name),
    .writer_ready (writer_ready),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .write_done   (write_done),
    .write_error  (write_error),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observation of the BRAM port and the status pulses
  int          cyc = 0;
  logic [45:0] got_q[$];
  logic [45:0] exp_q[$];
  logic [31:0] mem[int];
  logic [31:0] elems[$];
  int          we_cnt = 0, done_cnt = 0, err_cnt = 0;
  int          first_we_cyc = -1, last_we_cyc = 0, done_cyc = 0, err_cyc = 0;
  int          idle_we_viol = 0;
  int          req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      got_q.push_back({bram_addr, bram_din});
      we_cnt++;
      last_we_cyc = cyc;
      if (first_we_cyc < 0) first_we_cyc = cyc;
      if (writer_ready !== 1'b0) idle_we_viol++;
    end
    if (write_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (write_error === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  // Reference model: expected BRAM writes for one transfer of n elements
  task automatic model_xfer(input int id, input int r, input int c, input logic [63:0] nm, input int n);
    int base;
    base = id * 1152;
    exp_q.push_back({14'(base + 0), 8'(r), 8'(c), 16'h0000});
    exp_q.push_back({14'(base + 1), nm[31:0]});
    exp_q.push_back({14'(base + 2), nm[63:32]});
    for (int i = 0; i < n; i++) exp_q.push_back({14'(base + 3 + i), elems[i]});
  endtask

  task automatic fill_elems(input int n, input bit counting);
    elems.delete();
    for (int i = 0; i < n; i++) elems.push_back(counting ? 32'(i + 1) : $urandom);
  endtask

  task automatic req(input int id, input int r, input int c, input logic [63:0] nm, input bit hold);
    @(posedge clk); #1;
    write_req   = 1'b1;
    matrix_id   = 3'(id);
    rows        = 8'(r);
    cols        = 8'(c);
    matrix_name = nm;
    req_cyc     = cyc;
    first_we_cyc = -1;
    if (!hold) begin
      @(posedge clk); #1;
      write_req = 1'b0;
    end
  endtask

  // mode 0: back-to-back, 1: toggling valid, 2: random valid
  task automatic send(input int n, input int mode);
    bit tog;
    bit sent;
    bit rdy;
    int budget;
    tog = 1'b1;
    for (int i = 0; i < n; i++) begin
      sent   = 1'b0;
      budget = 0;
      while (!sent && budget < 200) begin
        case (mode)
          0:       data_valid = 1'b1;
          1:       data_valid = tog;
          default: data_valid = 1'($urandom_range(0, 1));
        endcase
        tog     = ~tog;
        data_in = elems[i];
        @(negedge clk);
        rdy = data_ready;
        @(posedge clk); #1;
        if (data_valid && rdy) sent = 1'b1;
        budget++;
      end
      if (!sent) begin
        check("send_timeout", 64'(i), 64'(n));
        i = n;
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int k;
    k = 0;
    while (done_cnt == start && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt - start), 64'd1);
  endtask

  task automatic verify(input string tag);
    int n;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 64'(got_q[i][45:32]), 64'(exp_q[i][45:32]));
      check({tag, "_data"}, 64'(got_q[i][31:0]), 64'(exp_q[i][31:0]));
      mem[int'(got_q[i][45:32])] = got_q[i][31:0];
    end
    check({tag, "_we_in_idle"}, 64'(idle_we_viol), 64'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  64'(writer_ready), 64'd1);
    check({tag, "_dready"}, 64'(data_ready),   64'd0);
    check({tag, "_done"},   64'(write_done),   64'd0);
    check({tag, "_err"},    64'(write_error),  64'd0);
    check({tag, "_we"},     64'(bram_we),      64'd0);
    check({tag, "_addr"},   64'(bram_addr),    64'd0);
    check({tag, "_din"},    64'(bram_din),     64'd0);
  endtask

  task automatic bad_req(input string tag, input int id, input int r, input int c);
    int e0;
    int w0;
    e0 = err_cnt;
    w0 = we_cnt;
    req(id, r, c, 64'h0, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check({tag, "_err_pulse"}, 64'(err_cnt - e0), 64'd1);
    check({tag, "_err_cyc"}, 64'(err_cyc - req_cyc), 64'd1);
    check({tag, "_no_we"}, 64'(we_cnt - w0), 64'd0);
    check({tag, "_ready"}, 64'(writer_ready), 64'd1);
  endtask

  task automatic good_xfer(input string tag, input int id, input int r, input int c,
                           input logic [63:0] nm, input int mode, input bit counting);
    int d0;
    fill_elems(r * c, counting);
    model_xfer(id, r, c, nm, r * c);
    d0 = done_cnt;
    req(id, r, c, nm, 1'b0);
    send(r * c, mode);
    wait_done(tag, d0);
    check({tag, "_done_lat"}, 64'(done_cyc - last_we_cyc), 64'd1);
    check({tag, "_first_we"}, 64'(first_we_cyc - req_cyc), 64'd1);
    verify(tag);
  endtask

  initial begin
    int d0;
    int id, r, c, kind, mode;
    logic [63:0] nm;
    logic [31:0] wd;

    rst         = 1'b1;
    write_req   = 1'b0;
    matrix_id   = '0;
    rows        = '0;
    cols        = '0;
    matrix_name = '0;
    data_in     = '0;
    data_valid  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: 2x3 into block 2, counting data, then decode the block back
    good_xfer("basic", 2, 2, 3, "MATRIX_A", 0, 1'b1);
    wd = mem[2304];
    check("basic_dimword", 64'(wd), 64'h02030000);
    check("basic_rows", 64'(wd[31:24]), 64'd2);
    check("basic_cols", 64'(wd[23:16]), 64'd3);
    check("basic_name", {mem[2306], mem[2305]}, "MATRIX_A");
    check("basic_last", 64'(mem[2312]), 64'd6);

    good_xfer("toggle", 2, 2, 3, "MATRIX_A", 1, 1'b1);

    bad_req("rows0", 1, 0, 5);
    bad_req("cols0", 1, 5, 0);
    bad_req("big", 3, 34, 34);

    good_xfer("one", 7, 1, 1, 64'h0123456789abcdef, 0, 1'b0);
    check("one_last_addr", 64'(last_we_cyc > 0 ? mem.exists(8067) : 0), 64'd1);

    good_xfer("max", 0, 33, 34, 64'hfeedface_cafef00d, 0, 1'b0);
    check("max_last_val", 64'(mem[1124]), 64'(elems[1121]));

    // Request held high through DATA: re-accepted only once the first transfer finishes
    fill_elems(4, 1'b0);
    model_xfer(1, 2, 2, 64'h1111_2222_3333_4444, 4);
    d0 = done_cnt;
    req(1, 2, 2, 64'h1111_2222_3333_4444, 1'b1);
    send(4, 0);
    wait_done("hold1", d0);
    @(posedge clk); #1;
    write_req = 1'b0;
    check("hold_busy", 64'(writer_ready), 64'd0);
    fill_elems(4, 1'b0);
    model_xfer(1, 2, 2, 64'h1111_2222_3333_4444, 4);
    d0 = done_cnt;
    send(4, 2);
    wait_done("hold2", d0);
    verify("hold");

    // Reset in the middle of DATA: partial block stays, outputs clear at once
    fill_elems(16, 1'b0);
    model_xfer(3, 4, 4, 64'h5555_6666_7777_8888, 5);
    req(3, 4, 4, 64'h5555_6666_7777_8888, 1'b0);
    send(5, 0);
    @(negedge clk);
    @(posedge clk); #1;
    check("pre_rst_dready", 64'(data_ready), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    verify("midrst");
    good_xfer("after_rst", 3, 4, 4, 64'h9999_aaaa_bbbb_cccc, 2, 1'b0);

    // Randomized mix of legal and rejected requests
    for (int t = 0; t < 16; t++) begin
      id   = $urandom_range(0, 7);
      kind = $urandom_range(0, 4);
      mode = $urandom_range(0, 2);
      nm   = {$urandom, $urandom};
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0:       bad_req("rnd_bad", id, 0, $urandom_range(0, 255));
          1:       bad_req("rnd_bad", id, $urandom_range(1, 255), 0);
          2:       bad_req("rnd_bad", id, $urandom_range(40, 255), $urandom_range(40, 255));
          default: bad_req("rnd_bad", id, 34, 34);
        endcase
      end else begin
        r = $urandom_range(1, 6);
        c = $urandom_range(1, 6);
        good_xfer("rnd", id, r, c, nm, mode, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
